// File: rtl/vram_tdp_be.sv
// True dual-port single-clock RAM with byte enables, selectable read-during-write,
// optional output register and a sweep engine that fills the array with CLEAR_VALUE.
module vram_tdp_be #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    BYTE_WIDTH     = 8,
    parameter string                 RDW_MODE       = "WRITE_FIRST",
    parameter int                    OUT_REG        = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter string                 MEM_FILE_NAME  = "none",
    localparam int                   NB             = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  coll,
    input  logic                  a_ena,
    input  logic [NB-1:0]         a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_ena,
    input  logic [NB-1:0]         b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
    // A preloaded image must survive reset, so the reset sweep is suppressed.
    localparam bit CLR_AT_RESET = (CLEAR_ON_RESET != 0) && (MEM_FILE_NAME == "none");
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   clr_cnt, clr_cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_acc, b_acc;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_merged, b_merged;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  a_v1, b_v1;

    assign busy  = (state == CLEAR);
    assign a_acc = a_ena && !busy;
    assign b_acc = b_ena && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLR_AT_RESET ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each port's own write merged over the stored word; feeds WRITE_FIRST reads.
    always_comb begin
        a_old    = mem[a_addr];
        b_old    = mem[b_addr];
        a_merged = a_old;
        b_merged = b_old;
        for (int i = 0; i < NB; i++) begin
            if (a_we[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (b_we[i]) b_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Port B bytes are issued before port A so A wins any overlapping byte.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_ena && b_we[i])
                    mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            for (int i = 0; i < NB; i++) begin
                if (a_ena && a_we[i])
                    mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            coll <= 1'b0;
        end else begin
            a_v1 <= a_acc;
            b_v1 <= b_acc;
            if (a_acc) a_q <= WRITE_FIRST ? a_merged : a_old;
            if (b_acc) b_q <= WRITE_FIRST ? b_merged : b_old;
            coll <= a_acc && b_acc && (a_addr == b_addr) && (|(a_we & b_we));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_dout  <= '0;
                    b_dout  <= '0;
                    a_valid <= 1'b0;
                    b_valid <= 1'b0;
                end else begin
                    a_dout  <= a_q;
                    b_dout  <= b_q;
                    a_valid <= a_v1;
                    b_valid <= b_v1;
                end
            end
        end else begin : g_noreg
            assign a_dout  = a_q;
            assign b_dout  = b_q;
            assign a_valid = a_v1;
            assign b_valid = b_v1;
        end
    endgenerate

endmodule

// File: tb/tb_vram_tdp_be.sv
// Bench for vram_tdp_be: a WRITE_FIRST/no-output-register instance and a READ_FIRST/
// output-register instance share stimulus and are checked against a behavioural model.
module tb_vram_tdp_be;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          NB    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'h5A5A_A5A5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_req;
    logic          a_ena, b_ena;
    logic [NB-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    logic          busy0, coll0, a_valid0, b_valid0;
    logic [DW-1:0] a_dout0, b_dout0;
    logic          busy1, coll1, a_valid1, b_valid1;
    logic [DW-1:0] a_dout1, b_dout1;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    vram_tdp_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE("WRITE_FIRST"),
        .OUT_REG(0), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1), .MEM_FILE_NAME("none")
    ) u_wf (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0), .coll(coll0),
        .a_ena(a_ena), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_valid(a_valid0),
        .b_ena(b_ena), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_valid(b_valid0)
    );

    vram_tdp_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE("READ_FIRST"),
        .OUT_REG(1), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1), .MEM_FILE_NAME("none")
    ) u_rf (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1), .coll(coll1),
        .a_ena(a_ena), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_valid(a_valid1),
        .b_ena(b_ena), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_valid(b_valid1)
    );

    // Reference model: array contents, sweep progress and expected port results.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy;
    int          m_clr_idx;
    bit          e_coll;
    logic [31:0] e0_adout, e0_bdout, e1_adout, e1_bdout, s1_a, s1_b;
    bit          e0_av, e0_bv, e1_av, e1_bv, s1_av, s1_bv;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] din,
                                               input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < NB; i++)
            if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    task automatic modelEdge();
        bit          a_acc, b_acc;
        logic [31:0] a_old, b_old;
        if (!rst_n) begin
            m_busy = 1; m_clr_idx = 0; e_coll = 0;
            e0_adout = '0; e0_bdout = '0; e1_adout = '0; e1_bdout = '0; s1_a = '0; s1_b = '0;
            e0_av = 0; e0_bv = 0; e1_av = 0; e1_bv = 0; s1_av = 0; s1_bv = 0;
            return;
        end
        a_acc  = a_ena && !m_busy;
        b_acc  = b_ena && !m_busy;
        a_old  = m_mem[a_addr];
        b_old  = m_mem[b_addr];
        e_coll = a_acc && b_acc && (a_addr == b_addr) && ((a_we & b_we) != 4'b0);
        // Registered-output instance presents what the first stage held last cycle.
        e1_adout = s1_a; e1_av = s1_av;
        e1_bdout = s1_b; e1_bv = s1_bv;
        if (a_acc) begin e0_adout = mergeBytes(a_old, a_din, a_we); s1_a = a_old; end
        if (b_acc) begin e0_bdout = mergeBytes(b_old, b_din, b_we); s1_b = b_old; end
        e0_av = a_acc; s1_av = a_acc;
        e0_bv = b_acc; s1_bv = b_acc;
        if (m_busy) begin
            m_mem[m_clr_idx] = CV;
            m_clr_idx++;
            if (m_clr_idx == DEPTH) m_busy = 0;
        end else begin
            if (b_acc) m_mem[b_addr] = mergeBytes(m_mem[b_addr], b_din, b_we);
            if (a_acc) m_mem[a_addr] = mergeBytes(m_mem[a_addr], a_din, a_we);
            if (clr_req) begin m_busy = 1; m_clr_idx = 0; end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] req);
        vec_count++;
        assert (obs === req) else begin
            err_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic checkOutput();
        checkValue("busy_wf",    32'(busy0),    32'(m_busy));
        checkValue("busy_rf",    32'(busy1),    32'(m_busy));
        checkValue("coll_wf",    32'(coll0),    32'(e_coll));
        checkValue("coll_rf",    32'(coll1),    32'(e_coll));
        checkValue("a_valid_wf", 32'(a_valid0), 32'(e0_av));
        checkValue("b_valid_wf", 32'(b_valid0), 32'(e0_bv));
        checkValue("a_dout_wf",  a_dout0,       e0_adout);
        checkValue("b_dout_wf",  b_dout0,       e0_bdout);
        checkValue("a_valid_rf", 32'(a_valid1), 32'(e1_av));
        checkValue("b_valid_rf", 32'(b_valid1), 32'(e1_bv));
        checkValue("a_dout_rf",  a_dout1,       e1_adout);
        checkValue("b_dout_rf",  b_dout1,       e1_bdout);
    endtask

    // Drives one cycle of inputs at the falling edge, then models and checks the rising edge.
    task automatic applyStimulus(input logic ae, input logic [3:0] awe, input logic [3:0] aaddr,
                                 input logic [31:0] adin, input logic be, input logic [3:0] bwe,
                                 input logic [3:0] baddr, input logic [31:0] bdin, input logic clr);
        a_ena = ae; a_we = awe; a_addr = aaddr; a_din = adin;
        b_ena = be; b_we = bwe; b_addr = baddr; b_din = bdin;
        clr_req = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic randomCycle(input bit force_ena, input bit clr);
        logic [3:0] aa, ba;
        aa = 4'($urandom_range(0, 15));
        ba = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
        applyStimulus(force_ena | 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, aa, $urandom,
                      force_ena | 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, ba, $urandom, clr);
    endtask

    initial begin
        int busy_len;
        rst_n = 1'b0; clr_req = 1'b0;
        a_ena = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
        b_ena = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
        @(negedge clk);
        repeat (3) idleCycle();

        $display("[TB] reset release sweep");
        rst_n = 1'b1;
        busy_len = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy0) busy_len++;
            idleCycle();
        end
        checkValue("sweep_len", 32'(busy_len), 32'd16);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(DEPTH-1-i), 32'h0, 1'b0);
            checkValue("clear_a", a_dout0, CV);
            checkValue("clear_b", b_dout0, CV);
        end
        repeat (2) idleCycle();

        $display("[TB] byte-enable merge");
        applyStimulus(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checkValue("merge_lat1", a_dout0, 32'hAA22CC44);
        idleCycle();
        checkValue("merge_lat2", a_dout1, 32'hAA22CC44);

        $display("[TB] same-port read-during-write");
        applyStimulus(1'b1, 4'hF, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checkValue("rdw_write_first", a_dout0, 32'h12345678);
        idleCycle();
        checkValue("rdw_read_first", a_dout1, 32'h0);

        $display("[TB] dual write same address");
        applyStimulus(1'b1, 4'hC, 4'd7, 32'hFFFF0000, 1'b1, 4'h3, 4'd7, 32'h0000FFFF, 1'b0);
        checkValue("coll_disjoint", 32'(coll0), 32'd0);
        applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checkValue("disjoint_word", a_dout0, 32'hFFFFFFFF);
        applyStimulus(1'b1, 4'hF, 4'd7, 32'h11111111, 1'b1, 4'hF, 4'd7, 32'h22222222, 1'b0);
        checkValue("coll_overlap", 32'(coll0), 32'd1);
        applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checkValue("coll_pulse_end", 32'(coll0), 32'd0);
        checkValue("a_wins", a_dout0, 32'h11111111);

        $display("[TB] cross-port read vs write");
        applyStimulus(1'b1, 4'hF, 4'd9, 32'h0BAD0BAD, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'hF, 4'd9, 32'hDEADBEEF, 1'b0);
        checkValue("cross_old", a_dout0, 32'h0BAD0BAD);
        applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        checkValue("cross_new", a_dout0, 32'hDEADBEEF);
        repeat (2) idleCycle();

        $display("[TB] clear request, ignored re-request, mid-sweep reset");
        repeat (10) randomCycle(1'b0, 1'b0);
        randomCycle(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) randomCycle(1'b1, k == 4);
        rst_n = 1'b0;
        idleCycle();
        rst_n = 1'b1;
        busy_len = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy0) busy_len++;
            randomCycle(1'b1, 1'b0);
        end
        checkValue("restart_len", 32'(busy_len), 32'd16);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) randomCycle(1'b0, $urandom_range(0, 63) == 0);
        repeat (20) randomCycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
